// File: rtl/proc_hier_if.sv
// Memory-side bus of the proc_hier core: instruction fetch port plus a
// single data port. Both memories answer combinationally in the same cycle.
interface proc_hier_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [15:0] dmem_rdata;

  // core side
  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_re,
    input  dmem_rdata
  );

  // memory side
  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_re,
    output dmem_rdata
  );
endinterface

// File: rtl/proc_hier.sv
// Single-cycle 16-bit processor: fetch, decode, execute, memory access and
// writeback all complete inside one clk period. The trace outputs describe
// the instruction executing in the current cycle.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | executing instructions, PC advances every edge
//   HALTED   | HALT was executed; PC, registers, memory and counter frozen
//
module proc_hier (
  input  logic               clk,
  input  logic               rst_n,
  proc_hier_if.master        mem,
  output logic [15:0]        pc,
  output logic [15:0]        inst,
  output logic               reg_write,
  output logic [2:0]         write_reg,
  output logic [15:0]        write_data,
  output logic               mem_read,
  output logic               mem_write,
  output logic               halt,
  output logic [31:0]        cycle_count
);

  localparam logic [4:0] OpHalt = 5'b00000;
  localparam logic [4:0] OpNop  = 5'b00001;
  localparam logic [4:0] OpAddi = 5'b01000;
  localparam logic [4:0] OpAlu  = 5'b11011;
  localparam logic [4:0] OpSt   = 5'b10000;
  localparam logic [4:0] OpLd   = 5'b10001;
  localparam logic [4:0] OpLbi  = 5'b11000;
  localparam logic [4:0] OpBeqz = 5'b01100;
  localparam logic [4:0] OpBnez = 5'b01101;
  localparam logic [4:0] OpJ    = 5'b00100;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } runState_e;

  runState_e   stateQ, stateD;
  logic [15:0] pcQ, pcNext, pcPlus2;
  logic [31:0] cycleCntQ;
  logic [15:0] regFile [8];

  logic [4:0]  opcode;
  logic [15:0] rsVal, rtVal;
  logic [15:0] imm5Sext, imm8Sext, imm11Sext;
  logic        isHaltOp, isLd;
  logic        regWe, memWe, memRe;
  logic [2:0]  regDst;
  logic [15:0] aluData;
  logic [15:0] memAddr;
  logic        commitEn;

  assign inst      = mem.imem_data;
  assign opcode    = inst[15:11];
  assign rsVal     = regFile[inst[10:8]];
  assign rtVal     = regFile[inst[7:5]];
  assign imm5Sext  = {{11{inst[4]}}, inst[4:0]};
  assign imm8Sext  = {{8{inst[7]}}, inst[7:0]};
  assign imm11Sext = {{5{inst[10]}}, inst[10:0]};
  assign pcPlus2   = pcQ + 16'd2;

  // Effective address is independent of the read data, so the LD path
  // through the external memory never loops back into decode.
  assign memAddr   = rsVal + imm5Sext;

  // Instruction decode, ALU and next-PC selection.
  always_comb begin
    isHaltOp = 1'b0;
    isLd     = 1'b0;
    regWe    = 1'b0;
    regDst   = 3'd0;
    aluData  = 16'h0000;
    memWe    = 1'b0;
    memRe    = 1'b0;
    pcNext   = pcPlus2;
    case (opcode)
      OpHalt: isHaltOp = 1'b1;
      OpNop:  ;
      OpAddi: begin
        regWe   = 1'b1;
        regDst  = inst[7:5];
        aluData = rsVal + imm5Sext;
      end
      OpAlu: begin
        regWe  = 1'b1;
        regDst = inst[4:2];
        case (inst[1:0])
          2'b00:   aluData = rsVal + rtVal;
          2'b01:   aluData = rtVal - rsVal;
          2'b10:   aluData = rsVal ^ rtVal;
          default: aluData = rsVal & ~rtVal;
        endcase
      end
      OpSt: memWe = 1'b1;
      OpLd: begin
        memRe  = 1'b1;
        isLd   = 1'b1;
        regWe  = 1'b1;
        regDst = inst[7:5];
      end
      OpLbi: begin
        regWe   = 1'b1;
        regDst  = inst[10:8];
        aluData = imm8Sext;
      end
      OpBeqz: if (rsVal == 16'h0000) pcNext = pcPlus2 + imm8Sext;
      OpBnez: if (rsVal != 16'h0000) pcNext = pcPlus2 + imm8Sext;
      OpJ:    pcNext = pcPlus2 + imm11Sext;
      default: ;
    endcase
  end

  // Halt is visible in the same cycle the HALT word is fetched; the sticky
  // state keeps it asserted afterwards.
  assign halt     = (stateQ == HALTED) || isHaltOp;

  // Nothing commits while halted or while reset is held.
  assign commitEn = rst_n && !halt;

  assign reg_write      = regWe && commitEn;
  assign write_reg      = reg_write ? regDst : 3'd0;
  assign write_data     = reg_write ? (isLd ? mem.dmem_rdata : aluData) : 16'h0000;

  assign mem.dmem_we    = memWe && commitEn;
  assign mem.dmem_re    = memRe && commitEn;
  assign mem.dmem_addr  = (mem.dmem_we || mem.dmem_re) ? memAddr : 16'h0000;
  assign mem.dmem_wdata = mem.dmem_we ? rtVal : 16'h0000;
  assign mem_write      = mem.dmem_we;
  assign mem_read       = mem.dmem_re;

  assign mem.imem_addr  = pcQ;
  assign pc             = pcQ;
  assign cycle_count    = cycleCntQ;

  // Run/halt state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= RUN;
    else        stateQ <= stateD;
  end

  // Run/halt next-state: HALT is the only way out of RUN, reset the only way back.
  always_comb begin
    stateD = stateQ;
    if (stateQ == RUN && isHaltOp) stateD = HALTED;
  end

  // Program counter; frozen while halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pcQ <= 16'h0000;
    else if (!halt) pcQ <= pcNext;
  end

  // Cycle counter; stops counting from the HALT cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cycleCntQ <= 32'd0;
    else if (!halt) cycleCntQ <= cycleCntQ + 32'd1;
  end

  // Register file write port; R0 is an ordinary register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regFile[i] <= 16'h0000;
    end else if (reg_write) begin
      regFile[write_reg] <= write_data;
    end
  end

endmodule

// File: tb/tb_proc_hier.sv
// Bench for proc_hier: directed programs plus random programs, checked
// cycle by cycle against an instruction-level reference model through a
// trace scoreboard.
module tb_proc_hier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc, inst, write_data;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  proc_hier_if bus ();

  proc_hier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (bus),
    .pc          (pc),
    .inst        (inst),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .halt        (halt),
    .cycle_count (cycle_count)
  );

  logic [15:0] imem   [0:32767];
  logic [15:0] busMem [0:65535];
  logic [15:0] refMem [0:65535];

  assign bus.imem_data  = imem[bus.imem_addr[15:1]];
  assign bus.dmem_rdata = busMem[bus.dmem_addr];

  always @(posedge clk) if (bus.dmem_we) busMem[bus.dmem_addr] <= bus.dmem_wdata;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        regWrite;
    logic [2:0]  writeReg;
    logic [15:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic        halt;
    logic        dRe;
    logic        dWe;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic [31:0] cycles;
  } trace_t;

  trace_t expQ[$];
  int     checks = 0;
  int     errors = 0;
  bit     monEn  = 1'b0;
  int     cycIdx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clearImem();
    for (int i = 0; i < 32768; i++) imem[i] = 16'h0800;
  endtask

  task automatic clearData();
    for (int i = 0; i < 65536; i++) begin
      busMem[i] = 16'h0000;
      refMem[i] = 16'h0000;
    end
  endtask

  // Reference model: architectural execution from reset for n cycles,
  // one expected trace record per cycle.
  task automatic buildExpected(input int n);
    logic [15:0] r [8];
    logic [15:0] p, np, w, a;
    logic [2:0]  rs, rt;
    bit          halted;
    int unsigned cnt;
    int          imm5, imm8, imm11;
    trace_t      t;
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    p = 16'h0000; halted = 1'b0; cnt = 0;
    for (int k = 0; k < n; k++) begin
      w     = imem[p[15:1]];
      rs    = w[10:8];
      rt    = w[7:5];
      imm5  = int'(w[4:0])  - (w[4]  ? 32   : 0);
      imm8  = int'(w[7:0])  - (w[7]  ? 256  : 0);
      imm11 = int'(w[10:0]) - (w[10] ? 2048 : 0);
      t        = '0;
      t.pc     = p;
      t.inst   = w;
      t.cycles = cnt;
      if (halted || w[15:11] == 5'b00000) begin
        t.halt = 1'b1;
        halted = 1'b1;
      end else begin
        cnt++;
        np = 16'(int'(p) + 2);
        case (w[15:11])
          5'b01000: begin
            t.regWrite = 1'b1; t.writeReg = rt;
            t.writeData = 16'(int'(r[rs]) + imm5);
          end
          5'b11011: begin
            t.regWrite = 1'b1; t.writeReg = w[4:2];
            case (w[1:0])
              2'd0: t.writeData = 16'(int'(r[rs]) + int'(r[rt]));
              2'd1: t.writeData = 16'(int'(r[rt]) - int'(r[rs]));
              2'd2: t.writeData = r[rs] ^ r[rt];
              default: t.writeData = r[rs] & ~r[rt];
            endcase
          end
          5'b10000: begin
            a = 16'(int'(r[rs]) + imm5);
            t.memWrite = 1'b1; t.dWe = 1'b1; t.dAddr = a; t.dWdata = r[rt];
            refMem[a] = r[rt];
          end
          5'b10001: begin
            a = 16'(int'(r[rs]) + imm5);
            t.memRead = 1'b1; t.dRe = 1'b1; t.dAddr = a;
            t.regWrite = 1'b1; t.writeReg = rt; t.writeData = refMem[a];
          end
          5'b11000: begin
            t.regWrite = 1'b1; t.writeReg = rs; t.writeData = 16'(imm8);
          end
          5'b01100: if (r[rs] == 0) np = 16'(int'(np) + imm8);
          5'b01101: if (r[rs] != 0) np = 16'(int'(np) + imm8);
          5'b00100: np = 16'(int'(np) + imm11);
          default: ;
        endcase
        if (t.regWrite) r[t.writeReg] = t.writeData;
        p = np;
      end
      expQ.push_back(t);
    end
  endtask

  // Scoreboard monitor: one trace record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    trace_t act, exp;
    if (monEn && rst_n) begin
      act.pc        = pc;
      act.inst      = inst;
      act.regWrite  = reg_write;
      act.writeReg  = write_reg;
      act.writeData = write_data;
      act.memRead   = mem_read;
      act.memWrite  = mem_write;
      act.halt      = halt;
      act.dRe       = bus.dmem_re;
      act.dWe       = bus.dmem_we;
      act.dAddr     = bus.dmem_addr;
      act.dWdata    = bus.dmem_wdata;
      act.cycles    = cycle_count;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL trace_unexpected cyc=%0d actual=%h required=none", cycIdx, act);
      end else begin
        exp = expQ.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL trace cyc=%0d actual=%h required=%h", cycIdx, act, exp);
        end
      end
      cycIdx++;
    end
  end

  task automatic runProg(input string nm, input int n);
    rst_n = 1'b0;
    monEn = 1'b0;
    clearData();
    expQ.delete();
    buildExpected(n);
    cycIdx = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    monEn = 1'b1;
    for (int i = 0; i < n + 4 && expQ.size() > 0; i++) @(posedge clk);
    monEn = 1'b0;
    chk({nm, "_drain"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  function automatic logic [15:0] randInst();
    int          sel;
    logic [15:0] w;
    sel = int'($urandom_range(0, 99));
    w   = 16'($urandom);
    if      (sel < 2)  w[15:11] = 5'b00000;
    else if (sel < 14) w[15:11] = 5'b01000;
    else if (sel < 27) w[15:11] = 5'b11011;
    else if (sel < 38) w[15:11] = 5'b10000;
    else if (sel < 49) w[15:11] = 5'b10001;
    else if (sel < 64) w[15:11] = 5'b11000;
    else if (sel < 72) begin w[15:11] = 5'b01100; w[7:4] = {4{w[3]}}; end
    else if (sel < 80) begin w[15:11] = 5'b01101; w[7:4] = {4{w[3]}}; end
    else if (sel < 85) begin w[15:11] = 5'b00100; w[10:4] = {7{w[3]}}; end
    else if (sel < 89) w[15:11] = 5'b00001;
    else if (w[15:11] == 5'b00000) w[15:11] = 5'b11111;
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    clearImem();
    clearData();

    // Reset state, with write-capable instructions sitting at address 0.
    imem[0] = 16'h8000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_cycles", cycle_count, 32'h0);
    chk("rst_dmem_we", 32'(bus.dmem_we), 32'h0);
    imem[0] = 16'hC105;
    #1;
    chk("rst_reg_write", 32'(reg_write), 32'h0);

    // LBI r1,5 ; ADDI r2,r1,-1
    clearImem();
    imem[0] = 16'hC105; imem[1] = 16'h415F; imem[2] = 16'h0000;
    runProg("lbi_addi", 5);

    // LBI r3,0x10 ; LBI r4,0x7F ; ST r4,r3,2 ; LD r5,r3,2
    clearImem();
    imem[0] = 16'hC310; imem[1] = 16'hC47F; imem[2] = 16'h8382;
    imem[3] = 16'h8BA2; imem[4] = 16'h0000;
    runProg("st_ld", 7);

    // BEQZ r0,+4 at 0x4 ; BNEZ r0,+4 at 0xA ; J -2 at 0x10
    clearImem();
    imem[2] = 16'h6004; imem[5] = 16'h6804; imem[8] = 16'h27FE;
    runProg("branch", 20);

    // HALT at 0x8, then reset clears it
    clearImem();
    imem[4] = 16'h0000;
    runProg("halt", 14);
    chk("halt_held", 32'(halt), 32'h1);
    chk("halt_pc_held", 32'(pc), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("halt_cleared", 32'(halt), 32'h0);
    chk("halt_rst_pc", 32'(pc), 32'h0);

    // Asynchronous reset pulse in the middle of an ST
    clearImem();
    clearData();
    imem[0] = 16'hC310; imem[1] = 16'hC47F; imem[2] = 16'h8382; imem[3] = 16'h0000;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("st_pc", 32'(pc), 32'h4);
    chk("st_we", 32'(bus.dmem_we), 32'h1);
    chk("st_addr", 32'(bus.dmem_addr), 32'h12);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_we", 32'(bus.dmem_we), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("async_no_write", 32'(busMem[16'h0012]), 32'h0);
    chk("async_restart_pc", 32'(pc), 32'h2);

    // Random programs
    for (int prog = 0; prog < 10; prog++) begin
      clearImem();
      for (int i = 0; i < 32; i++) imem[i] = randInst();
      runProg("random", 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_hier.md
PROC_HIER -- requirements
Module: proc_hier

Interface
REQ-001 The port list SHALL be exactly as follows: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  16  instruction fetch address; equals current PC.
- imem_data  in  16  instruction word at imem_addr; combinational, same cycle.
- dmem_addr  out  16  data memory byte address.
- dmem_wdata  out  16  data memory write data.
- dmem_we  out  1  data memory write strobe; the write commits on the rising edge.
- dmem_re  out  1  data memory read enable.
- dmem_rdata  in  16  read data at dmem_addr; combinational, same cycle.
- pc  out  16  PC of the instruction executing this cycle.
- inst  out  16  instruction executing this cycle.
- reg_write  out  1  register file written at the end of this cycle.
- write_reg  out  3  destination register.
- write_data  out  16  data written to the register file.
- mem_read  out  1  instruction is LD.
- mem_write  out  1  instruction is ST.
- halt  out  1  processor halted.
- cycle_count  out  32  cycles since reset.

Function
REQ-002 The processor SHALL be single-cycle: fetch, decode, execute, memory access and writeback complete within one clock.
REQ-003 The register file SHALL hold 8 x 16-bit registers, with combinational reads and a write on the rising edge; R0 SHALL NOT be hardwired.
REQ-004 Opcode SHALL be inst[15:11]; Rs=[10:8], Rt=[7:5]; sext() denotes sign extension to 16 bits.
REQ-005 00000 HALT SHALL assert halt combinationally, freeze the PC, and suppress all register and memory writes.
REQ-006 00001 NOP SHALL produce no writes; PC+=2.
REQ-007 01000 ADDI SHALL compute R[7:5] = Rs + sext(imm[4:0]).
REQ-008 11011 ALU ops SHALL write R[4:2], selected by func [1:0]:
- 00: Rs+Rt
- 01: Rt-Rs
- 10: Rs^Rt
- 11: Rs&~Rt
REQ-009 10000 ST SHALL write Mem[Rs+sext(imm5)] = R[7:5], with dmem_we=1 and mem_write=1.
REQ-010 10001 LD SHALL load R[7:5] = dmem_rdata from address Rs+sext(imm5), with dmem_re=1 and mem_read=1.
REQ-011 11000 LBI SHALL load Rs = sext(imm[7:0]).
REQ-012 01100 BEQZ / 01101 BNEZ SHALL compute, if Rs==0 / Rs!=0 respectively: PC = PC+2+sext(imm8); otherwise PC+2.
REQ-013 00100 J SHALL compute PC = PC+2+sext(inst[10:0]).
REQ-014 Every other opcode SHALL execute as a NOP.
REQ-015 All arithmetic SHALL be 16-bit modulo 2^16, with no flags; PC wraps from 0xFFFE to 0x0000.
REQ-016 mem_read and mem_write SHALL be mutually exclusive and never both 1.
REQ-017 dmem_re and dmem_we SHALL be 0 for all non-memory instructions.
REQ-018 dmem_addr and dmem_wdata SHALL be 0 when neither memory strobe is asserted.
REQ-019 write_data SHALL equal the value being committed whenever reg_write=1, and SHALL be 0 otherwise.
REQ-020 write_reg SHALL be 0 whenever reg_write=0.
REQ-021 halt SHALL be sticky until reset; once set, pc, inst, the registers and memory SHALL hold their values.
REQ-022 cycle_count SHALL increment every rising edge while rst_n=1 and halt=0, and SHALL hold once halt=1.
REQ-023 Outputs pc, inst, reg_write, write_reg, write_data, mem_read, mem_write and halt SHALL describe the same instruction in the same cycle, for trace sampling at the rising edge.

Reset
REQ-024 When rst_n=0, asynchronously: PC=0x0000, all registers=0x0000, cycle_count=0, sticky halt cleared.
REQ-025 During reset, reg_write and dmem_we SHALL be forced to 0.
REQ-026 Reset asserted mid-program SHALL abort the current instruction with no writes; the first fetch after release SHALL be from 0x0000.

Verification
REQ-027 Hold rst_n=0, then release -> pc=0x0000, halt=0, cycle_count=0, then 1 after the first edge.
REQ-028 LBI r1,5 then ADDI r2,r1,-1 -> cycle 1: reg_write=1, write_reg=1, write_data=0x0005; cycle 2: write_reg=2, write_data=0x0004, pc=0x0002.
REQ-029 LBI r3,0x10; LBI r4,0x7F; ST r4,r3,2; LD r5,r3,2 -> ST: dmem_addr=0x0012, dmem_wdata=0x007F, mem_write=1, reg_write=0; LD: mem_read=1, write_reg=5, write_data=0x007F.
REQ-030 BEQZ r0,+4 at pc=0x0004 with r0=0 -> next pc=0x000A; BNEZ r0,+4 with r0=0 -> next pc=pc+2; J -2 at 0x0010 -> next pc=0x0010.
REQ-031 HALT at 0x0008 -> halt=1 in that cycle; pc holds 0x0008 and cycle_count freezes on all later edges; subsequent reset clears halt.
REQ-032 Pulse rst_n low asynchronously between edges during an ST -> no memory write occurs; pc=0x0000 immediately.
